// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - ID/EXE hazard control: bubbles, stalls, redirects, forward selects
//
// Purpose: detects load-use hazards (D vs E) and taken branch/jump redirects resolved in E.
//   Inserts bubbles into ID/EXE via the active-low clrE_n, pre-decodes the E-stage forwarding
//   selects, and keeps saturating counts of load-use bubbles and redirect flushes.
// Ports:
//   clk, clr                      clock; synchronous active-high reset
//   rsD, rtD, useRsD, useRtD      source registers of the D instruction and whether they are read
//   regwriteE, memtoregE, writeRegE   E instruction writes regfile / is a load / destination
//   regwriteM, writeRegM          M instruction writes regfile / destination
//   takenE, jumpE, targetE        redirect request from E and its target
//   stallF, stallD, flushD, pcSel combinational pipeline controls (all 0 while clr=1)
//   pcTarget                      redirect target, mirrors targetE
//   clrE_n                        registered active-low ID/EXE clear
//   fwdAE, fwdBE                  registered forward selects: 00 regfile, 10 from M, 01 from W
//   stallCnt, flushCnt            saturating event counters
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             useRsD,
  input  logic             useRtD,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic [4:0]       writeRegE,
  input  logic             regwriteM,
  input  logic [4:0]       writeRegM,
  input  logic             takenE,
  input  logic             jumpE,
  input  logic [31:0]      targetE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             pcSel,
  output logic [31:0]      pcTarget,
  output logic             clrE_n,
  output logic [1:0]       fwdAE,
  output logic [1:0]       fwdBE,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUB_LU = 2'd1,
    BUB_BR = 2'd2
  } state_t;

  state_t     state, stateNext;
  logic       redir, luHaz, bubble;
  logic [1:0] fwdANext, fwdBNext;

  assign pcTarget = targetE;

  // In a bubble state E holds a cleared instruction, so its redirect and
  // load-use inputs are meaningless and are masked off here.
  always_comb begin
    redir     = 1'b0;
    luHaz     = 1'b0;
    stateNext = state;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    pcSel     = 1'b0;
    if (!clr && state == RUN) begin
      redir = takenE | jumpE;
      luHaz = memtoregE && regwriteE && (writeRegE != 5'd0) &&
              ((useRsD && rsD == writeRegE) || (useRtD && rtD == writeRegE));
    end
    case (state)
      RUN: begin
        // A redirect flushes the D instruction, making any load-use hazard moot.
        if (redir) begin
          pcSel     = 1'b1;
          flushD    = 1'b1;
          stateNext = BUB_BR;
        end else if (luHaz) begin
          stallF    = 1'b1;
          stallD    = 1'b1;
          stateNext = BUB_LU;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  assign bubble = redir | luHaz;

  // The E-stage producer is younger than M, so its match wins.
  always_comb begin
    fwdANext = 2'b00;
    fwdBNext = 2'b00;
    if (regwriteE && writeRegE != 5'd0 && writeRegE == rsD) fwdANext = 2'b10;
    else if (regwriteM && writeRegM != 5'd0 && writeRegM == rsD) fwdANext = 2'b01;
    if (regwriteE && writeRegE != 5'd0 && writeRegE == rtD) fwdBNext = 2'b10;
    else if (regwriteM && writeRegM != 5'd0 && writeRegM == rtD) fwdBNext = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= RUN;
      clrE_n   <= 1'b0;
      fwdAE    <= 2'b00;
      fwdBE    <= 2'b00;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      state  <= stateNext;
      clrE_n <= ~bubble;
      // A bubble carries no operands, so it gets no forwarding.
      fwdAE  <= bubble ? 2'b00 : fwdANext;
      fwdBE  <= bubble ? 2'b00 : fwdBNext;
      if (redir && flushCnt != '1) flushCnt <= flushCnt + 1'b1;
      if (luHaz && !redir && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  typedef struct {
    bit         clr;
    logic [4:0] rsD, rtD;
    bit         useRs, useRt, rwE, mtrE;
    logic [4:0] wrE;
    bit         rwM;
    logic [4:0] wrM;
    bit         tk, jp;
    logic [31:0] tgt;
    bit         eStall, eRedir, eClrEn;
    logic [1:0] eFwdA, eFwdB;
    int         eSc, eFc;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  rsD, rtD, writeRegE, writeRegM;
  logic        useRsD, useRtD, regwriteE, memtoregE, regwriteM, takenE, jumpE;
  logic [31:0] targetE;
  logic        stallF, stallD, flushD, pcSel, clrE_n;
  logic [31:0] pcTarget;
  logic [1:0]  fwdAE, fwdBE;
  logic [15:0] stallCnt, flushCnt;
  logic        stallF2, stallD2, flushD2, pcSel2, clrE_n2;
  logic [31:0] pcTarget2;
  logic [1:0]  fwdAE2, fwdBE2;
  logic [3:0]  stallCnt2, flushCnt2;

  int nVec = 0;
  int nBad = 0;

  // Reference model state
  bit         mBub = 1'b0;
  int         mSc = 0, mFc = 0, mSc2 = 0, mFc2 = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .clr(clr), .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .writeRegE(writeRegE),
    .regwriteM(regwriteM), .writeRegM(writeRegM), .takenE(takenE), .jumpE(jumpE),
    .targetE(targetE), .stallF(stallF), .stallD(stallD), .flushD(flushD), .pcSel(pcSel),
    .pcTarget(pcTarget), .clrE_n(clrE_n), .fwdAE(fwdAE), .fwdBE(fwdBE),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  pipeline_hazard_ctrl #(.CNT_W(4)) dutSat (
    .clk(clk), .clr(clr), .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .writeRegE(writeRegE),
    .regwriteM(regwriteM), .writeRegM(writeRegM), .takenE(takenE), .jumpE(jumpE),
    .targetE(targetE), .stallF(stallF2), .stallD(stallD2), .flushD(flushD2), .pcSel(pcSel2),
    .pcTarget(pcTarget2), .clrE_n(clrE_n2), .fwdAE(fwdAE2), .fwdBE(fwdBE2),
    .stallCnt(stallCnt2), .flushCnt(flushCnt2)
  );

  function automatic vec_t mk(input bit c, input int rs, input int rt, input bit uRs,
                              input bit uRt, input bit rwE, input bit mtrE, input int wrE,
                              input bit rwM, input int wrM, input bit tk, input bit jp,
                              input logic [31:0] tgt, input bit eSt, input bit eRd,
                              input bit eClr, input int eFA, input int eFB,
                              input int eSc, input int eFc);
    vec_t v;
    v.clr = c; v.rsD = 5'(rs); v.rtD = 5'(rt); v.useRs = uRs; v.useRt = uRt;
    v.rwE = rwE; v.mtrE = mtrE; v.wrE = 5'(wrE); v.rwM = rwM; v.wrM = 5'(wrM);
    v.tk = tk; v.jp = jp; v.tgt = tgt; v.eStall = eSt; v.eRedir = eRd; v.eClrEn = eClr;
    v.eFwdA = 2'(eFA); v.eFwdB = 2'(eFB); v.eSc = eSc; v.eFc = eFc;
    return v;
  endfunction

  function automatic logic [1:0] fwdOf(input vec_t v, input logic [4:0] src);
    if (v.rwE && v.wrE != 0 && v.wrE == src) return 2'b10;
    if (v.rwM && v.wrM != 0 && v.wrM == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check comb before the edge, check registers after it.
  task automatic step(input vec_t v, input bit useModel);
    vec_t e;
    bit   mRedir, mStall, bub;
    int   nSc, nFc, nSc2, nFc2;
    clr = v.clr; rsD = v.rsD; rtD = v.rtD; useRsD = v.useRs; useRtD = v.useRt;
    regwriteE = v.rwE; memtoregE = v.mtrE; writeRegE = v.wrE;
    regwriteM = v.rwM; writeRegM = v.wrM; takenE = v.tk; jumpE = v.jp; targetE = v.tgt;

    mRedir = !v.clr && !mBub && (v.tk || v.jp);
    mStall = !v.clr && !mBub && !mRedir && v.mtrE && v.rwE && v.wrE != 0 &&
             ((v.useRs && v.rsD == v.wrE) || (v.useRt && v.rtD == v.wrE));
    bub  = mRedir || mStall;
    nSc  = v.clr ? 0 : sat(mSc + int'(mStall), 65535);
    nFc  = v.clr ? 0 : sat(mFc + int'(mRedir), 65535);
    nSc2 = v.clr ? 0 : sat(mSc2 + int'(mStall), 15);
    nFc2 = v.clr ? 0 : sat(mFc2 + int'(mRedir), 15);
    e = v;
    if (useModel) begin
      e.eStall = mStall; e.eRedir = mRedir; e.eClrEn = !v.clr && !bub;
      e.eFwdA = (v.clr || bub) ? 2'b00 : fwdOf(v, v.rsD);
      e.eFwdB = (v.clr || bub) ? 2'b00 : fwdOf(v, v.rtD);
      e.eSc = nSc; e.eFc = nFc;
    end

    #3;
    chk("stallF", 32'(stallF), 32'(e.eStall));
    chk("stallD", 32'(stallD), 32'(e.eStall));
    chk("pcSel", 32'(pcSel), 32'(e.eRedir));
    chk("flushD", 32'(flushD), 32'(e.eRedir));
    if (!v.clr) chk("pcTarget", pcTarget, v.tgt);

    @(posedge clk);
    #1;
    mBub = !v.clr && bub;
    mSc = nSc; mFc = nFc; mSc2 = nSc2; mFc2 = nFc2;
    chk("clrE_n", 32'(clrE_n), 32'(e.eClrEn));
    chk("fwdAE", 32'(fwdAE), 32'(e.eFwdA));
    chk("fwdBE", 32'(fwdBE), 32'(e.eFwdB));
    chk("stallCnt", 32'(stallCnt), 32'(e.eSc));
    chk("flushCnt", 32'(flushCnt), 32'(e.eFc));
    chk("satStallCnt", 32'(stallCnt2), 32'(mSc2));
    chk("satFlushCnt", 32'(flushCnt2), 32'(mFc2));
    chk("satClrE_n", 32'(clrE_n2), 32'(e.eClrEn));
  endtask

  initial begin
    vec_t v;
    //            clr rs rt uRs uRt rwE mtr wrE rwM wrM tk jp tgt      st rd clr fA fB sc fc
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,    0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 32'h0,    1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 2, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 32'h0,    0, 0, 1, 2, 0, 1, 0));
    tbl.push_back(mk(0, 3, 3, 1, 1, 1, 0, 3, 1, 3, 0, 0, 32'h0,    0, 0, 1, 2, 2, 1, 0));
    tbl.push_back(mk(0, 3, 5, 1, 1, 1, 0, 0, 1, 3, 0, 0, 32'h0,    0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 5, 1, 1, 1, 0, 0, 1, 3, 0, 0, 32'h0,    0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h40,   0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h40,   0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 7, 0, 1, 1, 1, 7, 0, 0, 1, 0, 32'h80,   0, 1, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 0, 1, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 0, 1, 0, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 0, 1, 0, 0, 1, 3));
    tbl.push_back(mk(0, 4, 1, 0, 1, 1, 1, 4, 0, 0, 0, 0, 32'h0,    0, 0, 1, 2, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0,    0, 0, 1, 0, 0, 1, 3));
    tbl.push_back(mk(0, 6, 0, 1, 0, 1, 1, 6, 0, 0, 0, 0, 32'h0,    1, 0, 0, 0, 0, 2, 3));
    tbl.push_back(mk(1, 6, 0, 1, 0, 1, 1, 6, 0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6, 0, 1, 0, 1, 1, 6, 0, 0, 0, 0, 32'h0,    1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 0, 1, 0, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b0);

    // Saturation: drive the narrow counters well past all-ones.
    for (int i = 0; i < 20; i++) begin
      step(mk(0, 9, 0, 1, 0, 1, 1, 9, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    end
    for (int i = 0; i < 20; i++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100 + 32'(i), 0, 0, 0, 0, 0, 0, 0), 1'b1);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      v.clr   = ($urandom_range(0, 59) == 0);
      v.rsD   = 5'($urandom_range(0, 3));
      v.rtD   = 5'($urandom_range(0, 3));
      v.useRs = ($urandom_range(0, 3) != 0);
      v.useRt = ($urandom_range(0, 1) != 0);
      v.rwE   = ($urandom_range(0, 3) != 0);
      v.mtrE  = ($urandom_range(0, 1) != 0);
      v.wrE   = 5'($urandom_range(0, 3));
      v.rwM   = ($urandom_range(0, 1) != 0);
      v.wrM   = 5'($urandom_range(0, 3));
      v.tk    = ($urandom_range(0, 5) == 0);
      v.jp    = ($urandom_range(0, 9) == 0);
      v.tgt   = $urandom;
      step(v, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
